// File: rtl/onchip_loader_pkg.sv
// onchip_loader_pkg
// Shared definitions for the on-chip memory loader: controller state
// encoding, default geometry of the program memory and the byte-enable
// pattern used for every full-word access.
package onchip_loader_pkg;

  localparam int ADDR_W_DEF = 13;    // word-address width of the memory
  localparam int DEPTH_DEF  = 8192;  // 32-bit words in the memory
  localparam int RD_LAT_DEF = 1;     // read address -> read data latency

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_DRAIN,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/onchip_mem_loader_byte_word_packer.sv
// byte_word_packer
// Assembles a little-endian 32-bit word from an 8-bit valid/ready stream.
// The first accepted byte lands in bits 7:0, the fourth in bits 31:24.
// Ports:
//   clk          system clock
//   i_flush      synchronous clear of the lane counter and word (reset/start)
//   i_en         consumer can take bytes this cycle (drives o_ready)
//   i_data       stream byte
//   i_valid      stream byte valid
//   o_ready      byte accepted when i_valid & o_ready
//   o_word_last  the byte accepted this cycle completes a word
//   o_word       assembled word; complete the cycle after o_word_last
module byte_word_packer
  import onchip_loader_pkg::*;
(
  input  logic        clk,
  input  logic        i_flush,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_word_last,
  output logic [31:0] o_word
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic        w_accept;

  assign o_ready     = i_en;
  assign w_accept    = i_valid & i_en;
  assign o_word_last = w_accept & (r_lane == 2'd3);
  assign o_word      = r_word;

  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_lane <= 2'd0;
      r_word <= 32'd0;
    end else if (w_accept) begin
      r_lane <= r_lane + 2'd1;
      for (int i = 0; i < 4; i++) begin
        if (r_lane == i[1:0]) begin
          r_word[8*i +: 8] <= i_data;
        end
      end
    end
  end

endmodule

// File: rtl/onchip_mem_loader.sv
// onchip_mem_loader
// Avalon-MM initiator that fills the on-chip program memory from a byte
// stream, then reads the loaded region back and compares the sum of the
// read words against the sum of the written words.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, length_words        begin a load of length_words words (IDLE only)
//   s_data, s_valid, s_ready   boot byte stream, little-endian
//   avm_address .. avm_writedata  memory command outputs
//   avm_readdata               memory read data, RD_LAT cycles after address
//   busy, done, error          status; error is sticky until the next start
//   checksum                   mod-2^32 sum of the written words
module onchip_mem_loader
  import onchip_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   length_words,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_word_cnt;
  logic [ADDR_W:0]   r_rd_cnt;
  logic [31:0]       r_wsum;
  logic [31:0]       r_rsum;
  logic [RD_LAT-1:0] r_rd_pipe;
  logic              r_s_ready;
  logic [ADDR_W-1:0] r_address;
  logic [3:0]        r_be;
  logic              r_cs;
  logic              r_write;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [31:0]       r_checksum;

  logic              w_flush;
  logic              w_word_last;
  logic [31:0]       w_word;
  logic              w_issue;
  logic [RD_LAT:0]   w_pipe_shift;
  logic [RD_LAT-1:0] w_pipe_next;
  logic              w_rd_valid;
  logic [31:0]       w_rsum_next;
  logic [ADDR_W:0]   w_word_cnt_inc;

  // A new start discards any stale partial word left in the packer.
  assign w_flush = reset | ((r_state == ST_IDLE) & start);

  byte_word_packer u_packer (
    .clk         (clk),
    .i_flush     (w_flush),
    .i_en        (r_s_ready),
    .i_data      (s_data),
    .i_valid     (s_valid),
    .o_ready     (s_ready),
    .o_word_last (w_word_last),
    .o_word      (w_word)
  );

  // Read-valid pipe: a bit enters on every issued read and reaches the top
  // stage exactly when the memory presents that read's data.
  assign w_issue        = r_cs & ~r_write;
  assign w_pipe_shift   = {r_rd_pipe, w_issue};
  assign w_pipe_next    = w_pipe_shift[RD_LAT-1:0];
  assign w_rd_valid     = r_rd_pipe[RD_LAT-1];
  assign w_rsum_next    = r_rsum + (w_rd_valid ? avm_readdata : 32'd0);
  assign w_word_cnt_inc = r_word_cnt + LP_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_rd_cnt   <= '0;
      r_wsum     <= 32'd0;
      r_rsum     <= 32'd0;
      r_rd_pipe  <= '0;
      r_s_ready  <= 1'b0;
      r_address  <= '0;
      r_be       <= 4'd0;
      r_cs       <= 1'b0;
      r_write    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_checksum <= 32'd0;
    end else begin
      r_rd_pipe <= w_pipe_next;
      if (w_rd_valid) begin
        r_rsum <= w_rsum_next;
      end
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len      <= length_words;
            r_word_cnt <= '0;
            r_rd_cnt   <= '0;
            r_wsum     <= 32'd0;
            r_rsum     <= 32'd0;
            r_error    <= 1'b0;
            r_checksum <= 32'd0;
            if (length_words == '0) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else if (length_words > LP_DEPTH) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state   <= ST_FILL;
              r_busy    <= 1'b1;
              r_s_ready <= 1'b1;
            end
          end
        end

        ST_FILL: begin
          if (w_word_last) begin
            r_state   <= ST_WRITE;
            r_s_ready <= 1'b0;
            r_cs      <= 1'b1;
            r_write   <= 1'b1;
            r_be      <= BE_ALL;
            r_address <= r_word_cnt[ADDR_W-1:0];
          end
        end

        ST_WRITE: begin
          r_wsum     <= r_wsum + w_word;
          r_word_cnt <= w_word_cnt_inc;
          if (w_word_cnt_inc < r_len) begin
            r_state   <= ST_FILL;
            r_s_ready <= 1'b1;
            r_cs      <= 1'b0;
            r_write   <= 1'b0;
            r_be      <= 4'd0;
          end else begin
            // First verify read goes out directly behind the last write.
            r_state   <= ST_RD_ISSUE;
            r_write   <= 1'b0;
            r_cs      <= 1'b1;
            r_be      <= BE_ALL;
            r_address <= '0;
            r_rd_cnt  <= LP_ONE;
          end
        end

        ST_RD_ISSUE: begin
          // r_rd_cnt is the number of reads issued once this cycle ends.
          if (r_rd_cnt == r_len) begin
            r_state <= ST_RD_DRAIN;
            r_cs    <= 1'b0;
            r_be    <= 4'd0;
          end else begin
            r_address <= r_rd_cnt[ADDR_W-1:0];
            r_rd_cnt  <= r_rd_cnt + LP_ONE;
          end
        end

        ST_RD_DRAIN: begin
          // Leave as the last read datum is being summed, so done and the
          // verify result appear together.
          if (w_pipe_next == '0) begin
            r_state    <= ST_FINISH;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_error    <= r_error | (w_rsum_next != r_wsum);
            r_checksum <= r_wsum;
          end
        end

        ST_FINISH: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign avm_address    = r_address;
  assign avm_byteenable = r_be;
  assign avm_chipselect = r_cs;
  assign avm_write      = r_write;
  assign avm_writedata  = w_word;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign checksum       = r_checksum;

endmodule

// File: doc/onchip_mem_loader.md
# onchip_mem_loader

Avalon-MM initiator that fills the 8192×32 single-port on-chip program memory from a byte stream (flash reader or UART) and then reads the region back to verify it. It drives the memory's `address`/`byteenable`/`chipselect`/`write`/`writedata` inputs and consumes `readdata`. The memory never stalls and returns read data one cycle after the address is presented. It sits between the boot-source byte stream and the memory, and releases the CPU from reset only after a successful load.

## Interface
- `ADDR_W`, 13, word-address width of the memory
- `DEPTH`, 8192, number of 32-bit words in the memory
- `RD_LAT`, 1, cycles from read address to valid `avm_readdata`
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a load; ignored while `busy`
- `length_words`  in  ADDR_W+1  number of words to load; latched on `start`
- `s_data`  in  8  stream byte; little-endian, first byte → bits 7:0
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`
- `avm_address`  out  ADDR_W  word address
- `avm_byteenable`  out  4  always 4'hF when `avm_chipselect` is asserted, else 0
- `avm_chipselect`  out  1  bus access this cycle
- `avm_write`  out  1  write when set; read when clear and `avm_chipselect` is set
- `avm_writedata`  out  32  assembled word
- `avm_readdata`  in  32  memory read data
- `busy`  out  1  load or verify in progress
- `done`  out  1  one-cycle pulse at end of operation
- `error`  out  1  sticky until the next accepted `start`; verify mismatch or illegal length
- `checksum`  out  32  mod-2^32 sum of written words; valid from `done` until the next `start`

## Operation
- States: IDLE, FILL, WRITE, RD_ISSUE, RD_DRAIN, FINISH.
- IDLE, on `start`:
  - Latch the length, clear the counters, sums and `error`.
  - `length_words == 0` → FINISH. No bus traffic; checksum 0.
  - `length_words > DEPTH` → FINISH with `error = 1`. No bus traffic.
  - Otherwise → FILL.
- FILL:
  - `s_ready = 1`.
  - Shift accepted bytes into the word register at lane `byte_cnt[1:0]`.
  - On the 4th accepted byte → WRITE.
- WRITE (exactly 1 cycle):
  - `s_ready = 0`; `avm_chipselect = avm_write = 1`.
  - `avm_address = word_cnt`; `wsum += word`; `word_cnt++`.
  - Next state: FILL if `word_cnt + 1 < length`, else RD_ISSUE with the address counter reset to 0.
- RD_ISSUE:
  - One read per cycle at addresses 0..L-1 (`avm_write = 0`).
  - After the last address is issued → RD_DRAIN.
- Read accumulation: `avm_readdata` is added into `rsum` exactly `RD_LAT` cycles after each issued read. Implement this with a valid shift pipe `RD_LAT` deep.
- RD_DRAIN: wait until the pipe is empty → FINISH.
- FINISH (1 cycle):
  - `done = 1`; `error |= (rsum != wsum)`; `checksum = wsum`.
  - → IDLE.
- `start` is ignored in every state except IDLE. `s_ready = 0` outside FILL.
- Bytes beyond `4*length_words` are not consumed by this block.
- Reset in any state → IDLE immediately. Partial words are discarded; no further bus cycles are issued.

## Timing
- Reset values: `s_ready`, `avm_*`, `busy`, `done`, `error` = 0; `checksum` = 0.
- `busy` rises the cycle after `start` and falls the same cycle `done` pulses.
- Write of word n is on the bus the cycle after its 4th byte handshake. Peak rate is 4 bytes per 5 cycles.
- Verify takes L issue cycles plus `RD_LAT` drain cycles. `done` follows in the next cycle.
- Total cycles from `start` to `done` with a continuous stream: 5L + L + RD_LAT + 2.
- `s_valid` gaps during FILL stall only FILL. The bus is idle meanwhile: `avm_chipselect = 0`, `avm_byteenable = 0`.

## Structure
- Package `onchip_loader_pkg` holds:
  - The state enum.
  - Default `ADDR_W`/`DEPTH`/`RD_LAT` constants.
  - `BE_ALL = 4'hF`.
- One natural sub-module, `byte_word_packer`: 8→32 little-endian assembler with valid/ready and a `flush` driven by `reset`/`start`. Everything else stays in the top FSM.

## Test plan
- L=2, bytes 01 02 03 04 05 06 07 08 → writes 0x04030201 @0 and 0x08070605 @1; reads @0,@1; `checksum` = 0x0C0A0806; `error` = 0; `done` = 1 cycle.
- L=0 → `done` 2 cycles after `start`, no `avm_chipselect`, `error` = 0. L=8193 → `done` with `error` = 1, no bus traffic.
- L=4 with `s_valid` toggled randomly → same addresses/data as the continuous case; `s_ready` never asserted in the WRITE cycle.
- Force one `avm_readdata` word corrupted in the memory model during verify → `error` = 1 at `done`, stays set until the next `start`.
- Assert `reset` after 2 words are written with 2 bytes pending → all outputs at reset values the next cycle. A fresh L=1 load then writes @0 from new bytes only.
- `start` pulsed while `busy` → ignored; the length and sequence of the running load are unchanged. L=8192 full load → last write @8191; the address counter wraps only into the verify pass.
